// File: rtl/exc_pipe_pkg.sv
// Shared core definitions for the exception-tracking pipeline.
// Latency: none; constants and types only.
// Backpressure: none; constants and types only.
package exc_pipe_pkg;

  // Default widths of the rv6 core.
  localparam int DEF_XLEN    = 64;
  localparam int DEF_CAUSE_W = 6;

  // Exception cause codes.
  localparam logic [DEF_CAUSE_W-1:0] CAUSE_IAF     = 6'd1;
  localparam logic [DEF_CAUSE_W-1:0] CAUSE_II      = 6'd2;
  localparam logic [DEF_CAUSE_W-1:0] CAUSE_BRK     = 6'd3;
  localparam logic [DEF_CAUSE_W-1:0] CAUSE_LMA     = 6'd4;
  localparam logic [DEF_CAUSE_W-1:0] CAUSE_LAF     = 6'd5;
  localparam logic [DEF_CAUSE_W-1:0] CAUSE_SMA     = 6'd6;
  localparam logic [DEF_CAUSE_W-1:0] CAUSE_SAF     = 6'd7;
  localparam logic [DEF_CAUSE_W-1:0] CAUSE_ECALL_U = 6'd8;
  localparam logic [DEF_CAUSE_W-1:0] CAUSE_ECALL_S = 6'd9;
  localparam logic [DEF_CAUSE_W-1:0] CAUSE_ECALL_M = 6'd11;

  // Trap hand-off state.
  typedef enum logic {
    TRAP_IDLE = 1'b0,
    TRAP_PEND = 1'b1
  } trap_state_e;

endpackage

// File: rtl/exc_pipe_if.sv
// Bundle of pipeline-control, injection, late-source and trap handshake signals.
// Latency: none; wires only.
// Backpressure: trap_req is held until trap_ack; no other backpressure.
// Ports: master = pipeline/trap controller side, slave = exc_pipe.
interface exc_pipe_if #(
  parameter int STAGES  = 5,
  parameter int XLEN    = 64,
  parameter int CAUSE_W = 6,
  parameter int N_LATE  = 8,
  parameter int CNT_W   = 16
);
  logic [STAGES-1:0]         stall;
  logic [STAGES-1:0]         flush;
  logic [STAGES-1:0]         inj_vld;
  logic [STAGES*CAUSE_W-1:0] inj_cause;
  logic [STAGES*XLEN-1:0]    inj_val;
  logic [N_LATE-1:0]         late_vld;
  logic [N_LATE*CAUSE_W-1:0] late_cause;
  logic [N_LATE*XLEN-1:0]    late_val;
  logic                      commit_en;
  logic                      trap_ack;
  logic                      trap_req;
  logic [XLEN-1:0]           trap_cause;
  logic [XLEN-1:0]           trap_val;
  logic                      flush_req;
  logic [CNT_W-1:0]          trap_cnt;

  modport master (
    output stall, flush, inj_vld, inj_cause, inj_val,
    output late_vld, late_cause, late_val, commit_en, trap_ack,
    input  trap_req, trap_cause, trap_val, flush_req, trap_cnt
  );

  modport slave (
    input  stall, flush, inj_vld, inj_cause, inj_val,
    input  late_vld, late_cause, late_val, commit_en, trap_ack,
    output trap_req, trap_cause, trap_val, flush_req, trap_cnt
  );
endinterface

// File: rtl/exc_pipe_stage.sv
// One tracked pipeline register holding at most one exception (valid/cause/val).
// Latency: 1 clk from upstream or injection to this stage.
// Backpressure: stall holds the stage; a valid stalled stage is never overwritten.
// Ports: stall/flush control, up_* from the older neighbour, inj_* local detection, vld/cause/val out.
module exc_stage #(
  parameter int CAUSE_W = 6,
  parameter int XLEN    = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               up_vld,
  input  logic [CAUSE_W-1:0] up_cause,
  input  logic [XLEN-1:0]    up_val,
  input  logic               inj_vld,
  input  logic [CAUSE_W-1:0] inj_cause,
  input  logic [XLEN-1:0]    inj_val,
  output logic               vld,
  output logic [CAUSE_W-1:0] cause,
  output logic [XLEN-1:0]    val
);

  logic load;     // register updates this cycle
  logic take_up;  // source is the upstream stage rather than the injection

  // Flush beats everything; a moving stage prefers the older upstream exception;
  // a stalled empty stage may still capture its own detection.
  always_comb begin
    load    = 1'b0;
    take_up = 1'b0;
    if (!flush) begin
      if (!stall) begin
        load    = 1'b1;
        take_up = up_vld;
      end else if (inj_vld && !vld) begin
        load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= take_up ? 1'b1 : inj_vld;
    end
  end

  // Payload is only meaningful while vld is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      cause <= take_up ? up_cause : inj_cause;
      val   <= take_up ? up_val   : inj_val;
    end
  end

endmodule

// File: rtl/exc_pipe.sv
// Exception-tracking pipeline: STAGES exception registers plus prioritised late sources feeding one trap request.
// Latency: trap_req rises 1 clk after a commit cycle with a candidate.
// Backpressure: trap_req/cause/val held until trap_ack; candidates ignored while pending.
// Ports: clk, rst_n (async active-low), bus (exc_pipe_if slave: stage control, injections, late sources, trap handshake).
module exc_pipe
  import exc_pipe_pkg::*;
#(
  parameter int STAGES  = 5,
  parameter int XLEN    = DEF_XLEN,
  parameter int CAUSE_W = DEF_CAUSE_W,
  parameter int N_LATE  = 8,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  exc_pipe_if.slave  bus
);

  logic [STAGES-1:0]  s_vld;
  logic [CAUSE_W-1:0] s_cause [STAGES];
  logic [XLEN-1:0]    s_val   [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic               up_vld;
    logic [CAUSE_W-1:0] up_cause;
    logic [XLEN-1:0]    up_val;

    if (i == 0) begin : g_head
      // Youngest stage has no upstream; it only ever loads its own injection.
      assign up_vld   = 1'b0;
      assign up_cause = '0;
      assign up_val   = '0;
    end else begin : g_body
      assign up_vld   = s_vld[i-1];
      assign up_cause = s_cause[i-1];
      assign up_val   = s_val[i-1];
    end

    exc_stage #(
      .CAUSE_W (CAUSE_W),
      .XLEN    (XLEN)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .stall     (bus.stall[i]),
      .flush     (bus.flush[i]),
      .up_vld    (up_vld),
      .up_cause  (up_cause),
      .up_val    (up_val),
      .inj_vld   (bus.inj_vld[i]),
      .inj_cause (bus.inj_cause[i*CAUSE_W +: CAUSE_W]),
      .inj_val   (bus.inj_val[i*XLEN +: XLEN]),
      .vld       (s_vld[i]),
      .cause     (s_cause[i]),
      .val       (s_val[i])
    );
  end

  // Commit candidate: the oldest pipeline exception outranks every late source;
  // among late sources the lowest index wins (descending scan, last hit kept).
  logic               cand_vld;
  logic [CAUSE_W-1:0] cand_cause;
  logic [XLEN-1:0]    cand_val;

  always_comb begin
    cand_vld   = 1'b0;
    cand_cause = '0;
    cand_val   = '0;
    if (s_vld[STAGES-1]) begin
      cand_vld   = 1'b1;
      cand_cause = s_cause[STAGES-1];
      cand_val   = s_val[STAGES-1];
    end else begin
      for (int j = N_LATE-1; j >= 0; j--) begin
        if (bus.late_vld[j]) begin
          cand_vld   = 1'b1;
          cand_cause = bus.late_cause[j*CAUSE_W +: CAUSE_W];
          cand_val   = bus.late_val[j*XLEN +: XLEN];
        end
      end
    end
  end

  trap_state_e      state_q, state_d;
  logic [XLEN-1:0]  trap_cause_q, trap_cause_d;
  logic [XLEN-1:0]  trap_val_q, trap_val_d;
  logic [CNT_W-1:0] trap_cnt_q, trap_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= TRAP_IDLE;
      trap_cause_q <= '0;
      trap_val_q   <= '0;
      trap_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      trap_cause_q <= trap_cause_d;
      trap_val_q   <= trap_val_d;
      trap_cnt_q   <= trap_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    trap_val_d   = trap_val_q;
    trap_cnt_d   = trap_cnt_q;
    case (state_q)
      TRAP_IDLE: begin
        // trap_ack is deliberately not looked at here.
        if (bus.commit_en && cand_vld) begin
          state_d      = TRAP_PEND;
          trap_cause_d = {{(XLEN-CAUSE_W){1'b0}}, cand_cause};
          trap_val_d   = cand_val;
          trap_cnt_d   = (&trap_cnt_q) ? trap_cnt_q : trap_cnt_q + 1'b1;
        end
      end
      TRAP_PEND: begin
        // Outputs frozen; ack consumed here forces one IDLE cycle before the next trap.
        if (bus.trap_ack) begin
          state_d = TRAP_IDLE;
        end
      end
    endcase
  end

  // trap_req is a decode of the state flop, so it is registered and drops
  // asynchronously with rst_n.
  assign bus.trap_req   = (state_q == TRAP_PEND);
  assign bus.flush_req  = (state_q == TRAP_PEND);
  assign bus.trap_cause = trap_cause_q;
  assign bus.trap_val   = trap_val_q;
  assign bus.trap_cnt   = trap_cnt_q;

endmodule

// File: tb/tb_exc_pipe.sv
// Self-checking bench for exc_pipe: directed sequences, a late-source vector table and randomized traffic against a reference model.
module tb_exc_pipe;
  localparam int STAGES  = 5;
  localparam int XLEN    = 64;
  localparam int CAUSE_W = 6;
  localparam int N_LATE  = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exc_pipe_if #(.STAGES(STAGES), .XLEN(XLEN), .CAUSE_W(CAUSE_W), .N_LATE(N_LATE), .CNT_W(CNT_W)) bus ();

  exc_pipe #(.STAGES(STAGES), .XLEN(XLEN), .CAUSE_W(CAUSE_W), .N_LATE(N_LATE), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    logic [5:0]  c;
    logic [63:0] x;
  } ent_t;

  ent_t        m_st [STAGES];
  bit          m_pend;
  logic [63:0] m_cause;
  logic [63:0] m_val;
  int          m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < STAGES; i++) begin
      m_st[i].v = 1'b0; m_st[i].c = '0; m_st[i].x = '0;
    end
    m_pend = 1'b0; m_cause = '0; m_val = '0; m_cnt = 0;
  endfunction

  // Advance the model by one clock using the inputs currently on the bus.
  function automatic void model_step();
    ent_t        nx [STAGES];
    ent_t        inj;
    bit          cv;
    logic [5:0]  cc;
    logic [63:0] cx;
    for (int i = 0; i < STAGES; i++) begin
      inj.v = bus.inj_vld[i];
      inj.c = bus.inj_cause[i*CAUSE_W +: CAUSE_W];
      inj.x = bus.inj_val[i*XLEN +: XLEN];
      nx[i] = m_st[i];
      if (bus.flush[i]) begin
        nx[i].v = 1'b0;
      end else if (!bus.stall[i]) begin
        nx[i] = inj;
        if (i > 0) begin
          if (m_st[i-1].v) nx[i] = m_st[i-1];
        end
      end else if (inj.v && !m_st[i].v) begin
        nx[i] = inj;
      end
    end
    cv = 1'b0; cc = '0; cx = '0;
    if (m_st[STAGES-1].v) begin
      cv = 1'b1; cc = m_st[STAGES-1].c; cx = m_st[STAGES-1].x;
    end else begin
      for (int j = 0; j < N_LATE; j++) begin
        if (!cv && bus.late_vld[j]) begin
          cv = 1'b1;
          cc = bus.late_cause[j*CAUSE_W +: CAUSE_W];
          cx = bus.late_val[j*XLEN +: XLEN];
        end
      end
    end
    if (!m_pend) begin
      if (bus.commit_en && cv) begin
        m_pend  = 1'b1;
        m_cause = {58'd0, cc};
        m_val   = cx;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end else if (bus.trap_ack) begin
      m_pend = 1'b0;
    end
    for (int i = 0; i < STAGES; i++) m_st[i] = nx[i];
  endfunction

  // ---------------- helpers ----------------
  task automatic idle_inputs();
    bus.stall = '0; bus.flush = '0; bus.inj_vld = '0;
    bus.inj_cause = '0; bus.inj_val = '0;
    bus.late_vld = '0; bus.commit_en = 1'b0; bus.trap_ack = 1'b0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req"},   64'(bus.trap_req), 64'd0);
    chk({tag, "_flush"}, 64'(bus.flush_req), 64'd0);
    chk({tag, "_cause"}, bus.trap_cause, 64'd0);
    chk({tag, "_val"},   bus.trap_val, 64'd0);
    chk({tag, "_cnt"},   64'(bus.trap_cnt), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  logic [5:0]  lc [N_LATE];
  typedef struct {
    logic [7:0]  mask;
    bit          exp_req;
    logic [63:0] exp_cause;
    logic [63:0] exp_val;
  } lvec_t;
  lvec_t lv [6];

  int e_cnt;

  initial begin
    lc = '{6'd7, 6'd3, 6'd9, 6'd4, 6'd11, 6'd1, 6'd2, 6'd6};
    lv[0] = '{8'b0000_1010, 1'b1, 64'd3,  64'hA001};
    lv[1] = '{8'h01,        1'b1, 64'd7,  64'hA000};
    lv[2] = '{8'h80,        1'b1, 64'd6,  64'hA007};
    lv[3] = '{8'h0C,        1'b1, 64'd9,  64'hA002};
    lv[4] = '{8'h00,        1'b0, 64'd0,  64'd0};
    lv[5] = '{8'hF0,        1'b1, 64'd11, 64'hA004};

    rst_n = 1'b0;
    idle_inputs();
    for (int j = 0; j < N_LATE; j++) begin
      bus.late_cause[j*CAUSE_W +: CAUSE_W] = lc[j];
      bus.late_val[j*XLEN +: XLEN]         = 64'hA000 + 64'(j);
    end
    do_reset();
    e_cnt = 0;

    // 1: exception injected in stage 0 walks to commit; stage beats late sources.
    bus.inj_vld[0] = 1'b1;
    bus.inj_cause[0 +: CAUSE_W] = 6'd1;
    bus.inj_val[0 +: XLEN] = 64'h1000;
    step();
    bus.inj_vld = '0;
    for (int k = 1; k <= 4; k++) begin
      chk("t1_no_early_req", 64'(bus.trap_req), 64'd0);
      step();
    end
    chk("t1_no_req_c5", 64'(bus.trap_req), 64'd0);
    bus.commit_en = 1'b1;
    bus.late_vld = 8'hFF;
    step();
    e_cnt++;
    chk("t1_req", 64'(bus.trap_req), 64'd1);
    chk("t1_flush_req", 64'(bus.flush_req), 64'd1);
    chk("t1_cause", bus.trap_cause, 64'd1);
    chk("t1_val", bus.trap_val, 64'h1000);
    chk("t1_cnt", 64'(bus.trap_cnt), 64'(e_cnt));
    bus.commit_en = 1'b0; bus.late_vld = '0; bus.trap_ack = 1'b1;
    step();
    bus.trap_ack = 1'b0;
    chk("t1_req_drop", 64'(bus.trap_req), 64'd0);

    // 2: upstream cause 2 overrides cause-5 injection in stage 3.
    bus.inj_vld[2] = 1'b1;
    bus.inj_cause[2*CAUSE_W +: CAUSE_W] = 6'd2;
    bus.inj_val[2*XLEN +: XLEN] = 64'h2222;
    step();
    bus.inj_vld = '0;
    bus.inj_vld[3] = 1'b1;
    bus.inj_cause[3*CAUSE_W +: CAUSE_W] = 6'd5;
    bus.inj_val[3*XLEN +: XLEN] = 64'h5555;
    step();
    bus.inj_vld = '0;
    step();
    bus.commit_en = 1'b1;
    step();
    e_cnt++;
    chk("t2_req", 64'(bus.trap_req), 64'd1);
    chk("t2_cause", bus.trap_cause, 64'd2);
    chk("t2_val", bus.trap_val, 64'h2222);
    bus.trap_ack = 1'b1;
    step();
    bus.trap_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t2_lost_inj_no_trap", 64'(bus.trap_req), 64'd0);
      step();
    end
    bus.commit_en = 1'b0;

    // 3: late-source priority table.
    for (int v = 0; v < 6; v++) begin
      bus.late_vld = lv[v].mask;
      bus.commit_en = 1'b1;
      step();
      if (lv[v].exp_req) e_cnt++;
      chk("t3_req", 64'(bus.trap_req), 64'(lv[v].exp_req));
      if (lv[v].exp_req) begin
        chk("t3_cause", bus.trap_cause, lv[v].exp_cause);
        chk("t3_val", bus.trap_val, lv[v].exp_val);
      end
      chk("t3_cnt", 64'(bus.trap_cnt), 64'(e_cnt));
      bus.late_vld = '0; bus.commit_en = 1'b0; bus.trap_ack = lv[v].exp_req;
      step();
      chk("t3_req_drop", 64'(bus.trap_req), 64'd0);
      bus.trap_ack = 1'b0;
    end

    // 4: pending trap is frozen against new candidates until ack.
    bus.commit_en = 1'b1;
    bus.late_vld = 8'h01;
    step();
    e_cnt++;
    for (int k = 0; k < 4; k++) begin
      chk("t4_req_held", 64'(bus.trap_req), 64'd1);
      chk("t4_cause_held", bus.trap_cause, 64'd7);
      chk("t4_val_held", bus.trap_val, 64'hA000);
      chk("t4_cnt_once", 64'(bus.trap_cnt), 64'(e_cnt));
      bus.late_vld = 8'($urandom_range(2, 255));
      if (k == 3) bus.trap_ack = 1'b1;
      step();
    end
    chk("t4_req_after_ack", 64'(bus.trap_req), 64'd0);
    chk("t4_cnt_after_ack", 64'(bus.trap_cnt), 64'(e_cnt));
    // ack while IDLE must not block a new trap
    bus.late_vld = 8'h02;
    step();
    e_cnt++;
    chk("t4_idle_ack_ignored", 64'(bus.trap_req), 64'd1);
    chk("t4_idle_ack_cause", bus.trap_cause, 64'd3);
    bus.commit_en = 1'b0; bus.late_vld = '0;
    step();
    bus.trap_ack = 1'b0;
    chk("t4_req_drop2", 64'(bus.trap_req), 64'd0);

    // 5: flush beats a stalled-stage injection.
    bus.stall[2] = 1'b1;
    bus.flush[2] = 1'b1;
    bus.inj_vld[2] = 1'b1;
    bus.inj_cause[2*CAUSE_W +: CAUSE_W] = 6'd2;
    step();
    idle_inputs();
    bus.commit_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t5_no_trap", 64'(bus.trap_req), 64'd0);
    end
    bus.commit_en = 1'b0;

    // 6: counter saturation, then async reset while pending.
    do_reset();
    for (int t = 1; t <= CNT_MAX + 3; t++) begin
      bus.commit_en = 1'b1; bus.late_vld = 8'h01;
      step();
      chk("t6_cnt", 64'(bus.trap_cnt), 64'((t > CNT_MAX) ? CNT_MAX : t));
      bus.commit_en = 1'b0; bus.late_vld = '0; bus.trap_ack = 1'b1;
      step();
      bus.trap_ack = 1'b0;
    end
    bus.commit_en = 1'b1; bus.late_vld = 8'h04;
    step();
    bus.commit_en = 1'b0; bus.late_vld = '0;
    chk("t6_pend_req", 64'(bus.trap_req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("t6_async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < STAGES; i++) begin
        bus.stall[i]   = ($urandom_range(0, 3) == 0);
        bus.flush[i]   = ($urandom_range(0, 7) == 0);
        bus.inj_vld[i] = ($urandom_range(0, 3) == 0);
        bus.inj_cause[i*CAUSE_W +: CAUSE_W] = 6'($urandom);
        bus.inj_val[i*XLEN +: XLEN] = {$urandom, $urandom};
      end
      for (int j = 0; j < N_LATE; j++) begin
        bus.late_vld[j] = ($urandom_range(0, 7) == 0);
        bus.late_cause[j*CAUSE_W +: CAUSE_W] = 6'($urandom);
        bus.late_val[j*XLEN +: XLEN] = {$urandom, $urandom};
      end
      bus.commit_en = ($urandom_range(0, 1) == 1);
      bus.trap_ack  = ($urandom_range(0, 2) == 0);
      step();
      chk("rnd_req", 64'(bus.trap_req), 64'(m_pend));
      chk("rnd_flush_req", 64'(bus.flush_req), 64'(m_pend));
      chk("rnd_cause", bus.trap_cause, m_cause);
      chk("rnd_val", bus.trap_val, m_val);
      chk("rnd_cnt", 64'(bus.trap_cnt), 64'(m_cnt));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exc_pipe.md
Name: exc_pipe

Overview:
- Parametrised exception-tracking pipeline for the core.
- Carries at most one exception per in-flight instruction through STAGES pipeline registers and arbitrates it against late commit-stage sources.
- Presents a single registered trap request to the trap/CSR controller with a req/ack handshake.
- Generalises the fixed five-stage tracker: configurable depth and XLEN, per-stage injection, N_LATE prioritised late sources, trap hold-off FSM and a trap counter.

Parameters:
- STAGES, 5, number of tracked pipeline registers; stage 0 is youngest, STAGES-1 feeds commit.
- XLEN, 64, width of exception value and of trap_cause.
- CAUSE_W, 6, width of internal cause code.
- N_LATE, 8, number of commit-stage late sources; index 0 has highest priority.
- CNT_W, 16, width of the trap counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  STAGES  per-stage hold; bit i holds stage i register.
- flush  in  STAGES  per-stage kill; bit i clears stage i valid.
- inj_vld  in  STAGES  exception detected in stage i this cycle.
- inj_cause  in  STAGES*CAUSE_W  cause per stage, slice i at [i*CAUSE_W +: CAUSE_W].
- inj_val  in  STAGES*XLEN  tval per stage, same slicing.
- late_vld  in  N_LATE  commit-stage exception sources (ecall, ebreak, PMP, misaligned, CSR illegal).
- late_cause  in  N_LATE*CAUSE_W  causes of the late sources.
- late_val  in  N_LATE*XLEN  values of the late sources.
- commit_en  in  1  commit-stage instruction is valid and retiring this cycle.
- trap_ack  in  1  trap controller has taken the trap.
- trap_req  out  1  registered trap request.
- trap_cause  out  XLEN  zero-extended cause.
- trap_val  out  XLEN  trap value.
- flush_req  out  1  request to flush the whole pipeline; equals trap_req.
- trap_cnt  out  CNT_W  saturating count of traps issued.

Behaviour:
- Reset (async, rst_n=0): all stage valids 0, FSM IDLE, trap_req 0, flush_req 0, trap_cause 0, trap_val 0, trap_cnt 0. Stage cause/val registers need no reset.
- Stage i update, in priority order:
  1. flush[i]: valid <= 0.
  2. !stall[i]: load from stage i-1 if stage i-1 is valid, else load inj_{vld,cause,val}[i]. Stage 0 has no upstream and loads inj only.
  3. stall[i] with inj_vld[i] and stage i not valid: capture the injection.
  4. Otherwise hold.
- The upstream (older-detected) exception always wins over an injection in the same stage; a valid stage is never overwritten while stalled.
- A stage consumed downstream while its own stage is stalled stays put. Bubble insertion is the pipeline controller's job, enforced via flush.
- Commit candidate (combinational): stage STAGES-1 if valid; else the lowest-index set late_vld; else none.
- FSM:
  - IDLE: if commit_en and a candidate exists, register the cause (zero-extended to XLEN) and val into trap_cause/trap_val, set trap_req=1, increment trap_cnt (saturate at all-ones), go to PEND.
  - PEND: hold trap_req, trap_cause and trap_val stable. Ignore all candidates. On trap_ack, clear trap_req next cycle and return to IDLE.
  - trap_ack in IDLE is ignored.
- Latency: trap_req rises one clk after the commit cycle.
- Back-to-back: at least one IDLE cycle between traps, because the ack is consumed in PEND.
- Simultaneous flush and inject on the same stage: flush wins.
- No candidate while commit_en=0: no trap, and stage contents are retained per stall/flush.
- Reset mid-PEND: drops trap_req immediately (async).

Decomposition:
- Shared package (rv6 core defs): cause-code constants (IAF=1, II=2, BRK=3, LMA=4, LAF=5, SMA=6, SAF=7, ECALL_U=8, ECALL_S=9, ECALL_M=11), CAUSE_W, XLEN.
- Sub-module exc_stage: one valid/cause/val register with the stall/flush/inject rules, instantiated STAGES times in a generate loop.
- Late-source priority encoder and FSM stay inline.

Test Plan:
1. inj_vld[0], cause 1, val 0x1000; no stalls; commit_en=1 from cycle 5 -> trap_req rises at cycle 6 with cause 1, val 0x1000, trap_cnt=1.
2. Stage 2 holds cause 2 while inj_vld[3]=1 with cause 5 -> committed cause is 2, and the cause-5 injection is lost.
3. late_vld=0b1010 (index1 cause 3, index3 cause 4), pipeline empty, commit_en=1 -> trap_cause=3.
4. trap_req high, new candidate each cycle, trap_ack after 4 cycles -> trap_cause stable throughout, trap_req low the cycle after ack, trap_cnt +1 only.
5. stall[2]=1 with stage 2 empty and inj_vld[2]=1 cause 2; same cycle flush[2]=1 -> stage stays empty and no trap occurs.
6. Force trap_cnt near all-ones and issue 3 traps -> counter saturates; rst_n low mid-PEND -> trap_req 0 with no clock edge.
